// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - triggered two-channel ADC capture controller
// Waits for a level crossing on one channel, then streams cap_len+1 samples into a buffer.
module adc_capture_ctrl #(
    parameter int AW = 10,
    parameter int DW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    input  logic              trig_ch,
    input  logic              trig_rise,
    input  logic [DW-1:0]     trig_level,
    input  logic [AW-1:0]     cap_len,
    input  logic [DW-1:0]     ad_data_1,
    input  logic [DW-1:0]     ad_data_2,
    input  logic              ad_valid,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [2*DW-1:0]   wr_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } st_t;

    st_t                  st;
    logic [AW-1:0]        cfg_len;
    logic [AW-1:0]        addr_cnt;
    logic                 cfg_ch;
    logic                 cfg_rise;
    logic                 prev_ok;
    logic signed [DW-1:0] cfg_lvl;
    logic signed [DW-1:0] prev_s;
    logic signed [DW-1:0] cur_s;
    logic                 crossed;
    logic                 nat_trig;

    // Only the selected channel is tracked; prev_ok blocks the first sample after arm.
    always_comb begin
        cur_s    = cfg_ch ? ad_data_2 : ad_data_1;
        crossed  = cfg_rise ? ((prev_s < cfg_lvl) && (cur_s >= cfg_lvl))
                            : ((prev_s > cfg_lvl) && (cur_s <= cfg_lvl));
        nat_trig = ad_valid && prev_ok && crossed;
    end

    assign state = st;
    assign busy  = (st == S_ARMED) || (st == S_CAPTURE);
    assign done  = (st == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cfg_len  <= '0;
            cfg_ch   <= 1'b0;
            cfg_rise <= 1'b0;
            cfg_lvl  <= '0;
            prev_s   <= '0;
            prev_ok  <= 1'b0;
            addr_cnt <= '0;
        end else begin
            wr_en <= 1'b0;
            if (abort) begin
                st      <= S_IDLE;
                prev_ok <= 1'b0;
            end else begin
                case (st)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            cfg_len  <= cap_len;
                            cfg_ch   <= trig_ch;
                            cfg_rise <= trig_rise;
                            cfg_lvl  <= trig_level;
                            prev_ok  <= 1'b0;
                            addr_cnt <= '0;
                            st       <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (force_trig || nat_trig) begin
                            if (ad_valid) begin
                                // The triggering sample itself is the first one stored.
                                wr_en   <= 1'b1;
                                wr_addr <= '0;
                                wr_data <= {ad_data_2, ad_data_1};
                                if (cfg_len == '0) begin
                                    st <= S_DONE;
                                end else begin
                                    addr_cnt <= AW'(1);
                                    st       <= S_CAPTURE;
                                end
                            end else begin
                                addr_cnt <= '0;
                                st       <= S_CAPTURE;
                            end
                        end else if (ad_valid) begin
                            prev_s  <= cur_s;
                            prev_ok <= 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        if (ad_valid) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr_cnt;
                            wr_data <= {ad_data_2, ad_data_1};
                            if (addr_cnt == cfg_len) begin
                                st <= S_DONE;
                            end else begin
                                addr_cnt <= addr_cnt + AW'(1);
                            end
                        end
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 Parameter: AW, default 10, capture buffer address width (buffer depth 2^AW samples).
REQ-002 Parameter: DW, default 12, per-channel ADC sample width (signed, offset-removed two's complement).
REQ-003 clk  in  1  single capture clock (ADC sample clock domain); all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 arm  in  1  single-cycle request to start a trigger wait.
REQ-006 abort  in  1  return to IDLE from any state.
REQ-007 force_trig  in  1  immediate trigger while ARMED.
REQ-008 trig_ch  in  1  trigger source: 0 = channel 1, 1 = channel 2.
REQ-009 trig_rise  in  1  1 = rising-edge crossing, 0 = falling-edge crossing.
REQ-010 trig_level  in  DW  signed trigger threshold.
REQ-011 cap_len  in  AW  capture length minus one (samples = cap_len+1).
REQ-012 ad_data_1, ad_data_2  in  DW each  signed samples, channels 1/2.
REQ-013 ad_valid  in  1  samples valid this cycle.
REQ-014 wr_en  out  1  buffer write strobe.
REQ-015 wr_addr  out  AW  buffer write address.
REQ-016 wr_data  out  2*DW  {ad_data_2, ad_data_1} of the written sample.
REQ-017 busy  out  1  high in ARMED or CAPTURE.
REQ-018 done  out  1  high in DONE.
REQ-019 state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Function
REQ-020 IDLE: arm -> ARMED; other inputs ignored.
REQ-021 On arm acceptance (IDLE or DONE), cap_len, trig_ch, trig_rise and trig_level SHALL be latched; later changes have no effect until next arm.
REQ-022 ARMED: first ad_valid after arm only loads prev-sample register (cannot trigger); each later ad_valid compares prev and current of selected channel, then updates prev.
REQ-023 Rising trigger: prev < level AND cur >= level; falling: prev > level AND cur <= level; signed comparison.
REQ-024 Trigger or force_trig (force_trig also valid without ad_valid) -> CAPTURE; on a qualifying ad_valid the triggering sample SHALL be written at address 0; with force_trig alone the first ad_valid in CAPTURE goes to address 0.
REQ-025 CAPTURE: every ad_valid writes one sample at the next address (0,1,2,...); sample number cap_len+1 written -> DONE in that same cycle; no wrap, at most 2^AW writes per capture.
REQ-026 Write latency: wr_en, wr_addr, wr_data registered, asserted exactly one cycle after the accepted ad_valid; wr_en one cycle per sample.
REQ-027 DONE: done=1 held; arm -> ARMED (done clears next cycle, address counter reset to 0).
REQ-028 arm while ARMED or CAPTURE SHALL be ignored.
REQ-029 abort in any state -> IDLE next cycle; no wr_en issued for samples arriving in or after the abort cycle.
REQ-030 arm and abort same cycle: abort wins.
REQ-031 force_trig outside ARMED ignored; force_trig and natural trigger same cycle: single transition, sample written at address 0.
REQ-032 ad_valid low in CAPTURE: hold address, no write.

Reset
REQ-033 rst asserted: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, prev register and latched configuration cleared, immediately (asynchronous).
REQ-034 rst mid-capture: pending write dropped; after deassertion block waits in IDLE for arm.

Verification (AW=4, DW=12)
REQ-035 arm, trig_ch=0, rise, level=100, cap_len=3; ch1 ramp 0,50,150,200,250,300 every cycle -> trigger on 150; writes addr 0..3 data 150,200,250,300; done=1 one cycle after last write.
REQ-036 Falling, level=-10, ch2 samples 0,-20 -> trigger on -20 at addr 0; ch1 at or crossing level ignored since trig_ch=1.
REQ-037 First sample after arm already above level (level=0, samples 500,600) -> no trigger; state stays ARMED.
REQ-038 force_trig in ARMED with ad_valid low, cap_len=15 -> 16 writes addr 0..15, then DONE, no wrap to 0.
REQ-039 abort in CAPTURE after 2 writes, same cycle as arm and ad_valid -> IDLE, no further wr_en, arm ignored.
REQ-040 rst pulse at addr 5 of capture -> all outputs 0 asynchronously; re-arm afterwards restarts at addr 0.
